// File: rtl/rival_traffic_ctrl.sv
// Rival traffic generator: an LFSR picks spawn lanes, rivals scroll one step per
// frame and despawn past the bottom; a sticky collision freezes all traffic.

module rival_slot #(
    parameter int ROAD_X_MIN = 244,
    parameter int Y_SPAWN    = 150,
    parameter int Y_LIMIT    = 450,
    parameter int SPEED      = 1,
    parameter int CAR_W      = 14,
    parameter int CAR_H      = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       move,
    input  logic       spawn,
    input  logic [9:0] spawn_x,
    input  logic [9:0] car_x,
    input  logic [9:0] car_y,
    output logic       active,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       hit
);
    logic [10:0] y_next, dx, dy, adx, ady;

    // 11-bit sum so a y near 1023 cannot wrap below the limit
    assign y_next = {1'b0, y} + 11'(SPEED);

    always_ff @(posedge clk) begin
        if (rst) begin
            active <= 1'b0;
            x      <= 10'(ROAD_X_MIN);
            y      <= 10'(Y_SPAWN);
        end else if (move) begin
            if (active) begin
                if (y_next > 11'(Y_LIMIT))
                    active <= 1'b0;
                else
                    y <= y_next[9:0];
            end else if (spawn) begin
                active <= 1'b1;
                x      <= spawn_x;
                y      <= 10'(Y_SPAWN);
            end
        end
    end

    assign dx  = {1'b0, x} - {1'b0, car_x};
    assign dy  = {1'b0, y} - {1'b0, car_y};
    assign adx = dx[10] ? (~dx + 11'd1) : dx;
    assign ady = dy[10] ? (~dy + 11'd1) : dy;
    assign hit = active && (adx < 11'(CAR_W)) && (ady < 11'(CAR_H));
endmodule

module rival_traffic_ctrl #(
    parameter int         NUM_RIVALS = 3,
    parameter logic [7:0] LFSR_SEED  = 8'b10110101,
    parameter int         ROAD_X_MIN = 244,
    parameter int         LANE_SPAN  = 60,
    parameter int         Y_SPAWN    = 150,
    parameter int         Y_LIMIT    = 450,
    parameter int         SPEED      = 1,
    parameter int         SPAWN_GAP  = 40,
    parameter int         CAR_W      = 14,
    parameter int         CAR_H      = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    frame_tick,
    input  logic                    run,
    input  logic [9:0]              car_x,
    input  logic [9:0]              car_y,
    output logic [10*NUM_RIVALS-1:0] rival_x,
    output logic [10*NUM_RIVALS-1:0] rival_y,
    output logic [NUM_RIVALS-1:0]   rival_active,
    output logic                    collision,
    output logic [2:0]              collide_idx,
    output logic [7:0]              rnd
);
    localparam logic [7:0]  SEED     = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;
    localparam logic [15:0] GAP_LAST = 16'(SPAWN_GAP - 1);

    logic                         tick_go, at_gap, spawn_now;
    logic [15:0]                  spawn_cnt;
    logic [NUM_RIVALS-1:0]        free_oh, hit;
    logic [7:0]                   lane_off;
    logic [9:0]                   spawn_x;
    logic [2:0]                   hit_idx;
    logic [NUM_RIVALS-1:0][9:0]   rx, ry;

    always_ff @(posedge clk) begin
        if (rst)
            rnd <= SEED;
        else
            rnd <= {rnd[6:0], rnd[7] ^ rnd[5] ^ rnd[4] ^ rnd[3]};
    end

    assign tick_go   = frame_tick && run && !collision;
    assign at_gap    = (spawn_cnt == GAP_LAST);
    // lowest zero bit of the active mask, taken before this tick's despawns
    assign free_oh   = ~rival_active & (rival_active + NUM_RIVALS'(1));
    assign spawn_now = tick_go && at_gap && (|free_oh);
    assign lane_off  = 8'((16'(rnd) * 16'(LANE_SPAN)) >> 8);
    assign spawn_x   = 10'(ROAD_X_MIN) + {2'b00, lane_off};

    // saturates at the gap while all slots are busy so the spawn retries each tick
    always_ff @(posedge clk) begin
        if (rst)
            spawn_cnt <= '0;
        else if (tick_go) begin
            if (!at_gap)
                spawn_cnt <= spawn_cnt + 16'd1;
            else if (|free_oh)
                spawn_cnt <= '0;
        end
    end

    for (genvar i = 0; i < NUM_RIVALS; i++) begin : g_slot
        rival_slot #(
            .ROAD_X_MIN(ROAD_X_MIN), .Y_SPAWN(Y_SPAWN), .Y_LIMIT(Y_LIMIT),
            .SPEED(SPEED), .CAR_W(CAR_W), .CAR_H(CAR_H)
        ) u_slot (
            .clk     (clk),
            .rst     (rst),
            .move    (tick_go),
            .spawn   (spawn_now && free_oh[i]),
            .spawn_x (spawn_x),
            .car_x   (car_x),
            .car_y   (car_y),
            .active  (rival_active[i]),
            .x       (rx[i]),
            .y       (ry[i]),
            .hit     (hit[i])
        );
    end

    assign rival_x = rx;
    assign rival_y = ry;

    always_comb begin
        hit_idx = '0;
        for (int i = NUM_RIVALS - 1; i >= 0; i--)
            if (hit[i]) hit_idx = 3'(i);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            collision   <= 1'b0;
            collide_idx <= '0;
        end else if (run && !collision && (|hit)) begin
            collision   <= 1'b1;
            collide_idx <= hit_idx;
        end
    end
endmodule

// File: tb/tb_rival_traffic_ctrl.sv
// Directed bench: dut_a (SPAWN_GAP=4) covers spawn/motion/collision/reset,
// dut_b (SPAWN_GAP=1) covers slot saturation, respawn and run=0 hold.
`timescale 1ns/1ps

module tb_rival_traffic_ctrl;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a, rst_b, tick_a, tick_b, run_a, run_b;
    logic [9:0]  car_xa, car_ya, car_xb, car_yb;
    logic [29:0] rx_a, ry_a, rx_b, ry_b;
    logic [2:0]  act_a, act_b, idx_a, idx_b;
    logic        col_a, col_b;
    logic [7:0]  rnd_a, rnd_b;
    logic [7:0]  m_rnd;
    logic [9:0]  ex0, ex1, ex2;
    logic [7:0]  r;
    int total = 0;
    int bad   = 0;

    rival_traffic_ctrl #(.SPAWN_GAP(4)) dut_a (
        .clk(clk), .rst(rst_a), .frame_tick(tick_a), .run(run_a),
        .car_x(car_xa), .car_y(car_ya), .rival_x(rx_a), .rival_y(ry_a),
        .rival_active(act_a), .collision(col_a), .collide_idx(idx_a), .rnd(rnd_a)
    );

    rival_traffic_ctrl #(.SPAWN_GAP(1)) dut_b (
        .clk(clk), .rst(rst_b), .frame_tick(tick_b), .run(run_b),
        .car_x(car_xb), .car_y(car_yb), .rival_x(rx_b), .rival_y(ry_b),
        .rival_active(act_b), .collision(col_b), .collide_idx(idx_b), .rnd(rnd_b)
    );

    // reference LFSR for dut_a
    always @(posedge clk) begin
        if (rst_a) m_rnd <= 8'hB5;
        else       m_rnd <= {m_rnd[6:0], m_rnd[7] ^ m_rnd[5] ^ m_rnd[4] ^ m_rnd[3]};
    end

    function automatic logic [9:0] sl(input logic [29:0] v, input int i);
        return v[10*i +: 10];
    endfunction

    function automatic logic [9:0] xform(input logic [7:0] rv);
        int p;
        p = int'(rv) * 60;
        return 10'(244 + (p >> 8));
    endfunction

    task automatic tick_a1(output logic [7:0] rv);
        @(negedge clk);
        tick_a = 1'b1;
        rv = m_rnd;
        @(negedge clk);
        tick_a = 1'b0;
    endtask

    task automatic tick_b1();
        @(negedge clk);
        tick_b = 1'b1;
        @(negedge clk);
        tick_b = 1'b0;
    endtask

    task automatic test_reset();
        rst_a = 1'b1; rst_b = 1'b1; tick_a = 1'b0; tick_b = 1'b0;
        run_a = 1'b0; run_b = 1'b0;
        car_xa = '0; car_ya = '0; car_xb = '0; car_yb = '0;
        repeat (2) @(negedge clk);
        total++; if (act_a !== 3'b000) begin bad++; $display("FAIL reset_active got=%b exp=000", act_a); end
        total++; if (col_a !== 1'b0) begin bad++; $display("FAIL reset_collision got=%b exp=0", col_a); end
        total++; if (idx_a !== 3'd0) begin bad++; $display("FAIL reset_idx got=%0d exp=0", idx_a); end
        total++; if (rnd_a !== 8'hB5) begin bad++; $display("FAIL reset_rnd got=%h exp=b5", rnd_a); end
        total++; if (rnd_b !== 8'hB5) begin bad++; $display("FAIL reset_rnd_b got=%h exp=b5", rnd_b); end
        total++; if (act_b !== 3'b000) begin bad++; $display("FAIL reset_active_b got=%b exp=000", act_b); end
        for (int i = 0; i < 3; i++) begin
            total++; if (sl(rx_a, i) !== 10'd244) begin bad++; $display("FAIL reset_x%0d got=%0d exp=244", i, sl(rx_a, i)); end
            total++; if (sl(ry_a, i) !== 10'd150) begin bad++; $display("FAIL reset_y%0d got=%0d exp=150", i, sl(ry_a, i)); end
        end
        rst_a = 1'b0; rst_b = 1'b0;
        @(negedge clk);
        total++; if (rnd_a !== 8'h6B) begin bad++; $display("FAIL lfsr_step1 got=%h exp=6b", rnd_a); end
        @(negedge clk);
        total++; if (rnd_a !== 8'hD6) begin bad++; $display("FAIL lfsr_step2 got=%h exp=d6", rnd_a); end
    endtask

    task automatic test_spawn();
        run_a = 1'b1;
        repeat (3) tick_a1(r);
        total++; if (act_a !== 3'b000) begin bad++; $display("FAIL spawn_early got=%b exp=000", act_a); end
        tick_a1(r);
        ex0 = xform(r);
        total++; if (act_a !== 3'b001) begin bad++; $display("FAIL spawn_active got=%b exp=001", act_a); end
        total++; if (sl(ry_a, 0) !== 10'd150) begin bad++; $display("FAIL spawn_y got=%0d exp=150", sl(ry_a, 0)); end
        total++; if (sl(rx_a, 0) !== ex0) begin bad++; $display("FAIL spawn_x got=%0d exp=%0d", sl(rx_a, 0), ex0); end
        total++; if (sl(rx_a, 0) < 10'd244 || sl(rx_a, 0) > 10'd303) begin bad++; $display("FAIL spawn_x_range got=%0d exp=244..303", sl(rx_a, 0)); end
        total++; if (rnd_a !== m_rnd) begin bad++; $display("FAIL spawn_rnd got=%h exp=%h", rnd_a, m_rnd); end
    endtask

    task automatic test_motion();
        logic [9:0] ey [3];
        for (int t = 1; t <= 10; t++) begin
            tick_a1(r);
            if (t == 4) ex1 = xform(r);
            if (t == 8) ex2 = xform(r);
        end
        ey[0] = 10'd160; ey[1] = 10'd156; ey[2] = 10'd152;
        total++; if (act_a !== 3'b111) begin bad++; $display("FAIL motion_active got=%b exp=111", act_a); end
        for (int i = 0; i < 3; i++) begin
            total++; if (sl(ry_a, i) !== ey[i]) begin bad++; $display("FAIL motion_y%0d got=%0d exp=%0d", i, sl(ry_a, i), ey[i]); end
        end
        total++; if (sl(rx_a, 1) !== ex1) begin bad++; $display("FAIL motion_x1 got=%0d exp=%0d", sl(rx_a, 1), ex1); end
        total++; if (sl(rx_a, 2) !== ex2) begin bad++; $display("FAIL motion_x2 got=%0d exp=%0d", sl(rx_a, 2), ex2); end
        repeat (290) tick_a1(r);
        total++; if (sl(ry_a, 0) !== 10'd450 || act_a[0] !== 1'b1) begin bad++; $display("FAIL at_limit got=y%0d a%b exp=y450 a1", sl(ry_a, 0), act_a[0]); end
        tick_a1(r);
        total++; if (act_a !== 3'b110) begin bad++; $display("FAIL despawn_active got=%b exp=110", act_a); end
        total++; if (sl(ry_a, 0) !== 10'd450) begin bad++; $display("FAIL despawn_y got=%0d exp=450", sl(ry_a, 0)); end
        tick_a1(r);
        ex0 = xform(r);
        ey[0] = 10'd150; ey[1] = 10'd448; ey[2] = 10'd444;
        total++; if (act_a !== 3'b111) begin bad++; $display("FAIL respawn_active got=%b exp=111", act_a); end
        for (int i = 0; i < 3; i++) begin
            total++; if (sl(ry_a, i) !== ey[i]) begin bad++; $display("FAIL respawn_y%0d got=%0d exp=%0d", i, sl(ry_a, i), ey[i]); end
        end
        total++; if (sl(rx_a, 0) !== ex0) begin bad++; $display("FAIL respawn_x got=%0d exp=%0d", sl(rx_a, 0), ex0); end
    endtask

    task automatic test_full_slots();
        logic [9:0] ey [3];
        run_b = 1'b1;
        tick_b1();
        total++; if (act_b !== 3'b001) begin bad++; $display("FAIL full_t1 got=%b exp=001", act_b); end
        tick_b1();
        total++; if (act_b !== 3'b011) begin bad++; $display("FAIL full_t2 got=%b exp=011", act_b); end
        tick_b1();
        total++; if (act_b !== 3'b111) begin bad++; $display("FAIL full_t3 got=%b exp=111", act_b); end
        tick_b1();
        ey[0] = 10'd153; ey[1] = 10'd152; ey[2] = 10'd151;
        total++; if (act_b !== 3'b111) begin bad++; $display("FAIL full_t4 got=%b exp=111", act_b); end
        for (int i = 0; i < 3; i++) begin
            total++; if (sl(ry_b, i) !== ey[i]) begin bad++; $display("FAIL full_y%0d got=%0d exp=%0d", i, sl(ry_b, i), ey[i]); end
        end
        repeat (298) tick_b1();
        total++; if (act_b !== 3'b110) begin bad++; $display("FAIL full_despawn got=%b exp=110", act_b); end
        tick_b1();
        ey[0] = 10'd150; ey[1] = 10'd450; ey[2] = 10'd450;
        total++; if (act_b !== 3'b101) begin bad++; $display("FAIL full_refill got=%b exp=101", act_b); end
        for (int i = 0; i < 3; i++) begin
            total++; if (sl(ry_b, i) !== ey[i]) begin bad++; $display("FAIL refill_y%0d got=%0d exp=%0d", i, sl(ry_b, i), ey[i]); end
        end
        total++; if (sl(rx_b, 0) < 10'd244 || sl(rx_b, 0) > 10'd303) begin bad++; $display("FAIL refill_x_range got=%0d exp=244..303", sl(rx_b, 0)); end
    endtask

    task automatic test_run_low();
        @(negedge clk);
        run_b  = 1'b0;
        car_xb = sl(rx_b, 2);
        car_yb = 10'd450;
        repeat (10) tick_b1();
        total++; if (act_b !== 3'b101) begin bad++; $display("FAIL runlow_active got=%b exp=101", act_b); end
        total++; if (sl(ry_b, 0) !== 10'd150 || sl(ry_b, 2) !== 10'd450) begin bad++; $display("FAIL runlow_y got=%0d,%0d exp=150,450", sl(ry_b, 0), sl(ry_b, 2)); end
        total++; if (col_b !== 1'b0) begin bad++; $display("FAIL runlow_collision got=%b exp=0", col_b); end
        run_b = 1'b1;
        @(negedge clk);
        total++; if (col_b !== 1'b1) begin bad++; $display("FAIL run_collision got=%b exp=1", col_b); end
        total++; if (idx_b !== 3'd2) begin bad++; $display("FAIL run_idx got=%0d exp=2", idx_b); end
    endtask

    task automatic test_collision();
        logic [9:0] ey [3];
        // edges of the overlap box: |dy| == CAR_H and |dx| == CAR_W miss
        @(negedge clk);
        car_xa = ex0; car_ya = 10'd166;
        @(negedge clk);
        total++; if (col_a !== 1'b0) begin bad++; $display("FAIL edge_dy got=%b exp=0", col_a); end
        car_xa = ex0 + 10'd14; car_ya = 10'd150;
        @(negedge clk);
        total++; if (col_a !== 1'b0) begin bad++; $display("FAIL edge_dx got=%b exp=0", col_a); end
        // hit slot1 on the same edge as a frame tick: the move still lands
        car_xa = ex1; car_ya = 10'd463; tick_a = 1'b1;
        @(negedge clk);
        tick_a = 1'b0;
        ey[0] = 10'd151; ey[1] = 10'd449; ey[2] = 10'd445;
        total++; if (col_a !== 1'b1) begin bad++; $display("FAIL hit_collision got=%b exp=1", col_a); end
        total++; if (idx_a !== 3'd1) begin bad++; $display("FAIL hit_idx got=%0d exp=1", idx_a); end
        for (int i = 0; i < 3; i++) begin
            total++; if (sl(ry_a, i) !== ey[i]) begin bad++; $display("FAIL hit_move_y%0d got=%0d exp=%0d", i, sl(ry_a, i), ey[i]); end
        end
        repeat (20) tick_a1(r);
        total++; if (act_a !== 3'b111) begin bad++; $display("FAIL freeze_active got=%b exp=111", act_a); end
        for (int i = 0; i < 3; i++) begin
            total++; if (sl(ry_a, i) !== ey[i]) begin bad++; $display("FAIL freeze_y%0d got=%0d exp=%0d", i, sl(ry_a, i), ey[i]); end
        end
        total++; if (rnd_a !== m_rnd) begin bad++; $display("FAIL freeze_rnd got=%h exp=%h", rnd_a, m_rnd); end
        total++; if (col_a !== 1'b1 || idx_a !== 3'd1) begin bad++; $display("FAIL freeze_sticky got=%b/%0d exp=1/1", col_a, idx_a); end
    endtask

    task automatic test_mid_reset();
        @(negedge clk);
        rst_a = 1'b1; tick_a = 1'b1;
        @(negedge clk);
        rst_a = 1'b0; tick_a = 1'b0;
        car_xa = '0; car_ya = '0;
        total++; if (act_a !== 3'b000) begin bad++; $display("FAIL mid_active got=%b exp=000", act_a); end
        total++; if (col_a !== 1'b0 || idx_a !== 3'd0) begin bad++; $display("FAIL mid_collision got=%b/%0d exp=0/0", col_a, idx_a); end
        total++; if (rnd_a !== 8'hB5) begin bad++; $display("FAIL mid_rnd got=%h exp=b5", rnd_a); end
        total++; if (rx_a !== {3{10'd244}} || ry_a !== {3{10'd150}}) begin bad++; $display("FAIL mid_pos got=%h/%h exp=244s/150s", rx_a, ry_a); end
        repeat (3) tick_a1(r);
        total++; if (act_a !== 3'b000) begin bad++; $display("FAIL mid_residual got=%b exp=000", act_a); end
        tick_a1(r);
        ex0 = xform(r);
        total++; if (act_a !== 3'b001) begin bad++; $display("FAIL mid_spawn got=%b exp=001", act_a); end
        total++; if (sl(rx_a, 0) !== ex0) begin bad++; $display("FAIL mid_spawn_x got=%0d exp=%0d", sl(rx_a, 0), ex0); end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_spawn();
        test_motion();
        test_full_slots();
        test_run_low();
        test_collision();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
